// File: rtl/regfile_dump_tx_pkg.sv
// Shared definitions for the register-file dump transmitter.
//   state_t    : FSM state encoding, also exported on the debug state port
//   START_BIT  : serial line level during the start bit
//   STOP_BIT   : serial line level during the stop bit
//   IDLE_LINE  : serial line level when nothing is being sent
package regfile_dump_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic IDLE_LINE = 1'b1;

endpackage

// File: rtl/regfile_dump_tx_if.sv
// Signal bundle between the dump transmitter, the test controller and the
// register-file read port.
//   start : dump request pulse (controller -> dumper)
//   abort : stop the dump immediately (controller -> dumper)
//   busy  : dump in progress (dumper -> controller)
//   done  : one-cycle pulse after the last stop bit (dumper -> controller)
//   ra    : register-file read address (dumper -> register file)
//   rd    : combinational register-file read data (register file -> dumper)
//   tx    : 8N1 serial line, idle high
//
// Handshake: a request is start=1 for one cycle; it is taken only while busy=0
// (busy acts as "not ready"), so a start seen while busy=1 is simply lost.
// abort takes priority over start in the same cycle. busy drops in the same
// cycle done pulses, and the controller may issue the next start from then on.
interface regfile_dump_tx_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              tx;

    modport master (
        input  start, abort, rd,
        output busy, done, ra, tx
    );

    modport slave (
        output start, abort, rd,
        input  busy, done, ra, tx
    );
endinterface

// File: rtl/regfile_dump_tx_baud_tick.sv
// Bit-period timer for the dump transmitter.
//   clk   : system clock
//   reset : synchronous, active-high reset
//   clear : hold the counter at zero so the next bit starts a full period
//   tick  : high on the last cycle of each bit period
// The counter runs 0..CLKS_PER_BIT-1 and reloads on its own at each tick, so
// back-to-back bits never accumulate drift.
module regfile_dump_tx_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (cnt == LAST_CNT) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST_CNT);
endmodule

// File: rtl/regfile_dump_tx.sv
// Register-file dump transmitter.
// On start, walks read addresses FIRST_REG..LAST_REG through a spare read port
// and sends each register as one 8N1 frame (start 0, DATA_W bits LSB first,
// stop 1), frames back to back with a single FETCH cycle in between.
//   clk       : system clock, rising edge
//   reset     : synchronous, active-high reset
//   bus       : controller handshake, register-file read port and serial line
//   dbg_state : current FSM state
module regfile_dump_tx
    import regfile_dump_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIRST_REG    = 0,
    parameter int LAST_REG     = 15,
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 4
) (
    input  logic               clk,
    input  logic               reset,
    regfile_dump_tx_if.master  bus,
    output state_t             dbg_state
);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] FIRST_A  = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(LAST_REG);

    state_t            state, state_n;
    logic [DATA_W-1:0] shift, shift_n;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_n;
    logic [ADDR_W-1:0] ra, ra_n;
    logic              done_r, done_n;
    logic              tx_c, busy_c;
    logic              baud_clear, tick;

    regfile_dump_tx_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .reset(reset),
        .clear(baud_clear),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            ra      <= FIRST_A;
            done_r  <= 1'b0;
        end else begin
            state   <= state_n;
            shift   <= shift_n;
            bit_cnt <= bit_cnt_n;
            ra      <= ra_n;
            done_r  <= done_n;
        end
    end

    // tx and busy are decoded from registered state, so reset or abort
    // returns the line high in the very next cycle.
    always_comb begin
        state_n    = state;
        shift_n    = shift;
        bit_cnt_n  = bit_cnt;
        ra_n       = ra;
        done_n     = 1'b0;
        tx_c       = IDLE_LINE;
        busy_c     = 1'b1;
        baud_clear = 1'b0;

        case (state)
            S_IDLE: begin
                busy_c     = 1'b0;
                baud_clear = 1'b1;
                if (bus.start && !bus.abort) begin
                    ra_n    = FIRST_A;
                    state_n = S_FETCH;
                end
            end
            S_FETCH: begin
                // ra has been stable for a full cycle, so rd is settled here.
                baud_clear = 1'b1;
                shift_n    = bus.rd;
                bit_cnt_n  = '0;
                state_n    = S_START;
            end
            S_START: begin
                tx_c = START_BIT;
                if (tick) begin
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                tx_c = shift[0];
                if (tick) begin
                    shift_n = shift >> 1;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_n = '0;
                        state_n   = S_STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            S_STOP: begin
                tx_c = STOP_BIT;
                if (tick) begin
                    if (ra == LAST_A) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        ra_n    = ra + 1'b1;
                        state_n = S_FETCH;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Abort truncates whatever frame is in flight and never reports done.
        if (bus.abort && state != S_IDLE) begin
            state_n   = S_IDLE;
            bit_cnt_n = '0;
            done_n    = 1'b0;
        end
    end

    assign bus.ra    = ra;
    assign bus.tx    = tx_c;
    assign bus.busy  = busy_c;
    assign bus.done  = done_r;
    assign dbg_state = state;
endmodule
